// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional fixed priority: RAM_ARB_FIXED_PRIORITY_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam int RAM_AW = 9;
  localparam int RAM_DW = 32;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the two requesters.
// RAM_ARB_FIXED_PRIORITY_EN: port 0 always wins a tie.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic win
);

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    win = req0 ? P_FETCH : P_DATA;
  end
`else
  always_comb begin
    win = P_FETCH;
    unique case (1'b1)
      (req0 && req1):  win = ~last_grant;
      (req1 && !req0): win = P_DATA;
      default:         win = P_FETCH;
    endcase
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a 1-cycle-read single-port RAM.
// Tie policy via ram_arb_pick (RAM_ARB_FIXED_PRIORITY_EN).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t          state;
  state_t          state_nxt;
  logic            sel;
  logic            last_grant;
  logic            win;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;

  ram_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .win        (win)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= P_FETCH;
      last_grant <= P_DATA;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 || req1)) begin
        sel       <= win;
        cmd_we    <= win ? we1 : we0;
        cmd_addr  <= win ? addr1 : addr0;
        cmd_wdata <= win ? wdata1 : wdata0;
      end
      if (state == CAPTURE) begin
        if (sel == P_DATA) rdata1 <= mem_rdata;
        else               rdata0 <= mem_rdata;
      end
      if (state == ACK) last_grant <= sel;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_write = cmd_we;
        mem_read  = !cmd_we;
        state_nxt = cmd_we ? ACK : CAPTURE;
      end
      CAPTURE: begin
        state_nxt = ACK;
      end
      ACK: begin
        ack0      = (sel == P_FETCH);
        ack1      = (sel == P_DATA);
        state_nxt = IDLE;
      end
    endcase
  end

  // Command registers only move in IDLE, so the bus holds between accesses.
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a transaction-level model.
// Tie model follows RAM_ARB_FIXED_PRIORITY_EN when defined.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [8:0]  addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [8:0]  addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        ack0, ack1, busy;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  ram_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // RAM: registered read, write on posedge.
  bit [31:0] ram [512];
  always @(posedge clock) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_addr];
  end

  int proto_err = 0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_read && mem_write) proto_err <= proto_err + 1;
      if ((mem_read || mem_write) && !busy) proto_err <= proto_err + 1;
      if (ack0 && ack1) proto_err <= proto_err + 1;
    end
  end

  // Reference model state.
  bit [31:0] ref_mem [512];
  bit [31:0] exp_rd [2];
  bit        lg;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        we;
    logic [8:0]  a;
    logic [31:0] d;
  } acc_t;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input bit w);
    return w ? 2 : 3;
  endfunction

  function automatic bit pick(input bit r0, input bit r1);
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    return r0 ? 1'b0 : 1'b1;
`else
    if (r0 && r1) return ~lg;
    return r1;
`endif
  endfunction

  function automatic void model_do(input bit p, input bit w,
                                   input bit [8:0] a,
                                   input bit [31:0] d);
    if (w) ref_mem[a] = d;
    else   exp_rd[p] = ref_mem[a];
    lg = p;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 0; req1 = 0;
    lg = 1'b1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    repeat (2) @(negedge clock);
    check("rst_ctrl", {busy, ack0, ack1, mem_read, mem_write}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    reset_n = 1'b1;
  endtask

  task automatic run_txn(input bit r0, input bit r1,
                         input bit w0, input bit [8:0] a0,
                         input bit [31:0] d0,
                         input bit w1, input bit [8:0] a1,
                         input bit [31:0] d1,
                         input bit glitch);
    int   t_ack [2];
    int   exp_t [2];
    int   n, got, c, t;
    bit   f, s;
    acc_t q [$];
    acc_t e [2];
    @(negedge clock);
    check("idle", busy, 0);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    n = int'(r0) + int'(r1);
    f = pick(r0, r1);
    s = ~f;
    t_ack[0] = -1; t_ack[1] = -1;
    exp_t[0] = -1; exp_t[1] = -1;
    t = lat(f ? w1 : w0);
    exp_t[f] = t;
    if (n == 2) exp_t[s] = t + 1 + lat(s ? w1 : w0);
    e[0] = f ? acc_t'{w1, a1, d1} : acc_t'{w0, a0, d0};
    e[1] = s ? acc_t'{w1, a1, d1} : acc_t'{w0, a0, d0};
    got = 0;
    c = 0;
    while (got < n && c < 12) begin
      c++;
      @(posedge clock);
      #1;
      if (c == 1 && glitch) begin
        if (f) begin addr1 = ~a1; wdata1 = ~d1; end
        else   begin addr0 = ~a0; wdata0 = ~d0; end
      end
      @(negedge clock);
      if (mem_read || mem_write)
        q.push_back(acc_t'{mem_write, mem_addr, mem_wdata});
      if (ack0) begin t_ack[0] = c; req0 = 0; got++; end
      if (ack1) begin t_ack[1] = c; req1 = 0; got++; end
    end
    req0 = 0; req1 = 0;
    model_do(f, e[0].we, e[0].a, e[0].d);
    if (n == 2) model_do(s, e[1].we, e[1].a, e[1].d);
    check("ack0_cycle", t_ack[0], exp_t[0]);
    check("ack1_cycle", t_ack[1], exp_t[1]);
    check("rdata0", rdata0, exp_rd[0]);
    check("rdata1", rdata1, exp_rd[1]);
    check("acc_count", q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      check("acc_we", q[i].we, e[i].we);
      check("acc_addr", q[i].a, e[i].a);
      if (e[i].we) check("acc_wdata", q[i].d, e[i].d);
    end
  endtask

  task automatic hold_both(input bit [8:0] a0, input bit [8:0] a1);
    int n, c, last_t;
    bit g;
    @(negedge clock);
    check("idle", busy, 0);
    req0 = 1; we0 = 0; addr0 = a0;
    req1 = 1; we1 = 0; addr1 = a1;
    n = 0; c = 0; last_t = 0;
    while (n < 4 && c < 40) begin
      @(negedge clock);
      c++;
      if (ack0 || ack1) begin
        g = pick(1'b1, 1'b1);
        check("hold_grant", ack1, g);
        check("hold_gap", c - last_t, (n == 0) ? 3 : 4);
        model_do(g, 1'b0, g ? a1 : a0, 0);
        last_t = c;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    check("hold_acks", n, 4);
    check("hold_rdata0", rdata0, exp_rd[0]);
    check("hold_rdata1", rdata1, exp_rd[1]);
  endtask

  task automatic reset_in_capture();
    int acks;
    @(negedge clock);
    check("idle", busy, 0);
    req1 = 1; we1 = 0; addr1 = 9'h010;
    repeat (2) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    lg = 1'b1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack1", ack1, 0);
    check("mid_rst_rdata1", rdata1, 0);
    check("mid_rst_rdata0", rdata0, 0);
    req1 = 0;
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      if (ack0 || ack1) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    bit [1:0] r;
    bit [8:0] ra0, ra1;
    do_reset();
    run_txn(1, 0, 1, 9'h010, 32'hDEADBEEF, 0, 0, 0, 0);
    run_txn(1, 0, 0, 9'h010, 0, 0, 0, 0, 0);
    check("lit_deadbeef", rdata0, 32'hDEADBEEF);
    check("lit_rdata1_kept", rdata1, 0);
    do_reset();
    run_txn(1, 1, 0, 9'h010, 0, 0, 9'h011, 0, 0);
    hold_both(9'h010, 9'h1FF);
    run_txn(0, 1, 0, 0, 0, 1, 9'h1FF, 32'h12345678, 0);
    run_txn(1, 0, 0, 9'h1FF, 0, 0, 0, 0, 0);
    check("lit_boundary", rdata0, 32'h12345678);
    reset_in_capture();
    run_txn(0, 1, 0, 0, 0, 0, 9'h010, 0, 0);
    run_txn(1, 0, 1, 9'h020, 32'hA5A5_0F0F, 0, 0, 0, 1);
    run_txn(1, 0, 0, 9'h020, 0, 0, 0, 0, 1);
    for (int k = 0; k < 60; k++) begin
      r = 2'($urandom_range(1, 3));
      ra0 = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
      run_txn(r[0], r[1],
              1'($urandom_range(0, 1)), ra0, $urandom,
              1'($urandom_range(0, 1)), ra1, $urandom,
              ($urandom_range(0, 3) == 0));
    end
    @(negedge clock);
    check("protocol", proto_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the 512x32 single-port synchronous RAM. The RAM has a 1-cycle registered read and a write on posedge.
- Port 0 is instruction fetch; port 1 is data/MDR access.
- Serialises requests and drives the RAM Read/Write/address/DataIn.
- Captures DataOut into per-port read-data registers.
- Returns a one-cycle ack to the winning requester.

Parameters:
- AW, 9, RAM address width (512 words)
- DW, 32, RAM data width

Ports:
- clock  in  1  system clock; all state on posedge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held until ack0
- we0  in  1  port 0 write(1)/read(0); stable while req0
- addr0  in  AW  port 0 word address
- wdata0  in  DW  port 0 write data
- ack0  out  1  port 0 completion pulse
- rdata0  out  DW  port 0 read data; valid from ack0, held until next port-0 read
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- mem_read  out  1  to RAM Read
- mem_write  out  1  to RAM Write
- mem_addr  out  AW  to RAM address
- mem_wdata  out  DW  to RAM DataIn
- mem_rdata  in  DW  from RAM DataOut
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0) clears:
  - state=IDLE; all outputs 0.
  - rdata0/rdata1=0; last_grant=1, so port 0 wins the first tie.
- FSM states are IDLE, ACCESS, CAPTURE and ACK.
- IDLE:
  - If any req is high, pick a winner.
  - Latch its we/addr/wdata into command registers and its index into sel.
  - Go to ACCESS. With no req, stay in IDLE.
- ACCESS:
  - Drive mem_addr/mem_wdata from the command registers for exactly one cycle.
  - Assert mem_write if we=1, else mem_read.
  - Go to ACK on a write, or CAPTURE on a read.
- CAPTURE:
  - mem_read=0; mem_rdata is valid this cycle.
  - Load it into rdata[sel] at the end of the cycle.
  - Go to ACK.
- ACK:
  - ack[sel]=1 for this single cycle; update last_grant=sel.
  - Go to IDLE.
- mem_read and mem_write are never high together, and are high only in ACCESS.
- mem_addr and mem_wdata hold their last value outside ACCESS; this has no functional meaning.
- Latency, with req first sampled in IDLE at cycle 0:
  - write: ack at cycle 2
  - read: ack at cycle 3, rdata valid at cycle 3
  - minimum spacing between grants: 3 cycles (write) or 4 cycles (read)
- Arbitration is round-robin (default):
  - If only one req is high, it wins.
  - If both are high, the port != last_grant wins.
- Requester rules:
  - Keep req/we/addr/wdata stable until ack.
  - Requester must drop req in the cycle after ack unless issuing a new transaction. A still-high req is treated as a new request.
- Request changes after the IDLE latch are ignored for the in-flight transaction.
- A req deasserted before ack is protocol misuse; the latched transaction still completes.
- Reset mid-operation:
  - Immediate return to IDLE; no ack is issued.
  - A write issued in ACCESS may already be committed. Requesters must reissue.
- The rdata of the non-selected port is never modified.
- Address wrap does not apply: all 2^AW addresses are valid.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIORITY_EN.
- Defined: port 0 always wins a tie; last_grant is unused and optimised away. Port 1 can starve under continuous port 0 requests.
- Undefined: round-robin as above.

Decomposition:
- ram_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2, ACK=2'd3)
  - default AW/DW
  - port index constants P_FETCH=0 and P_DATA=1
- One natural sub-module, ram_arb_pick: combinational winner select from req0, req1 and last_grant, with the fixed-priority macro honoured inside it.
- The FSM and datapath stay in ram_arbiter.

Test Plan:
- Reset, then port 0 writes addr 9'h010 with 32'hDEADBEEF → mem_write high exactly 1 cycle with mem_addr=9'h010; ack0 at cycle 2.
- Port 0 reads 9'h010 → mem_read 1 cycle; ack0 at cycle 3 with rdata0=32'hDEADBEEF; rdata1 unchanged.
- req0 and req1 high simultaneously from reset, both reads → port 0 served first, then port 1. With both held continuously, grants alternate 0,1,0,1. With RAM_ARB_FIXED_PRIORITY_EN, grants are 0,0,0 while req0 is held.
- Port 1 writes 9'h1FF=32'h12345678, then port 0 reads 9'h1FF → rdata0=32'h12345678, confirming boundary address and cross-port coherence.
- Assert reset_n=0 during CAPTURE of a port 1 read → no ack1; busy=0 and rdata1=0 immediately; the next request is served normally.
- Change addr0 during ACCESS → mem_addr keeps the latched address; ack0 is returned for the original transaction.
